// File: rtl/wb_gpio_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_gpio_arbiter
// Brief   : Round-robin two-master Wishbone arbiter with stall watchdog in
//           front of the 8-bit GPIO slave.
// Revision: 1.0 - initial release
// ============================================================================
module wb_gpio_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       m0_adr_i,
  input  logic [7:0] m0_dat_i,
  input  logic       m0_we_i,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_adr_i,
  input  logic [7:0] m1_dat_i,
  input  logic       m1_we_i,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_adr_o,
  output logic [7:0] s_dat_o,
  output logic       s_we_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  input  logic       s_err_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] c_wdog_last =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_wdog;

  logic       w_g0, w_g1;
  logic       w_sel_cyc, w_sel_stb, w_sel_we, w_sel_adr;
  logic [7:0] w_sel_dat;
  logic       w_stall, w_timeout;

  always_comb begin
    w_g0      = (r_state == GNT0);
    w_g1      = (r_state == GNT1);
    w_sel_cyc = 1'b0;
    w_sel_stb = 1'b0;
    w_sel_we  = 1'b0;
    w_sel_adr = 1'b0;
    w_sel_dat = 8'h00;
    if (w_g0) begin
      w_sel_cyc = m0_cyc_i;
      w_sel_stb = m0_stb_i;
      w_sel_we  = m0_we_i;
      w_sel_adr = m0_adr_i;
      w_sel_dat = m0_dat_i;
    end else if (w_g1) begin
      w_sel_cyc = m1_cyc_i;
      w_sel_stb = m1_stb_i;
      w_sel_we  = m1_we_i;
      w_sel_adr = m1_adr_i;
      w_sel_dat = m1_dat_i;
    end
  end

  // A cycle that ends in ack or err is never a stall, so an ack always beats the watchdog.
  assign w_stall   = w_sel_stb & ~s_ack_i & ~s_err_i;
  assign w_timeout = (TIMEOUT_CYCLES > 0) && w_stall && (r_wdog == c_wdog_last);

  assign s_cyc_o  = w_sel_cyc & ~w_timeout;
  assign s_stb_o  = w_sel_stb & ~w_timeout;
  assign s_we_o   = w_sel_we;
  assign s_adr_o  = w_sel_adr;
  assign s_dat_o  = w_sel_dat;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = w_g0 & w_sel_stb & s_ack_i;
  assign m1_ack_o = w_g1 & w_sel_stb & s_ack_i;
  assign m0_err_o = w_g0 & ((w_sel_stb & s_err_i) | w_timeout);
  assign m1_err_o = w_g1 & ((w_sel_stb & s_err_i) | w_timeout);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_wdog       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (m0_cyc_i && (!m1_cyc_i || r_last_grant)) begin
            r_state      <= GNT0;
            r_last_grant <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state      <= GNT1;
            r_last_grant <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!w_sel_cyc || w_timeout) begin
            r_state <= IDLE;
            r_wdog  <= '0;
          end else if (w_stall && (TIMEOUT_CYCLES > 0)) begin
            r_wdog <= r_wdog + CNT_W'(1);
          end else begin
            r_wdog <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
